dict_decompressor: RTL and testbench

DICT_DECOMPRESSOR -- requirements
Module: dict_decompressor

---
 rtl/dict_pkg.sv | 28 ++
 rtl/byte_merge.sv | 23 ++
 rtl/dict_decompressor.sv | 96 +++++++++
 tb/tb_dict_decompressor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dict_pkg.sv
// Shared dictionary-coding definitions used by both the compressor and the decompressor.
// Holds the match-type encoding, default sizes and the matched-byte-count helper.
package dict_pkg;
  localparam int DICT_ENTRY_DEF = 16;
  localparam int DICT_WORD_DEF  = 32;

  typedef enum logic [1:0] {
    NO_MATCH   = 2'b00,
    MATCH2     = 2'b01,
    MATCH3     = 2'b10,
    MATCH_FULL = 2'b11
  } match_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } dec_state_t;

  // Number of bytes sourced from the dictionary word for a given match type.
  function automatic int match_bytes(match_t t, int nbytes);
    case (t)
      MATCH_FULL: return nbytes;
      MATCH3:     return 3;
      MATCH2:     return 2;
      default:    return 0;
    endcase
  endfunction
endpackage

// File: rtl/byte_merge.sv
// Combinational byte selector: each byte lane takes either the dictionary word or the literal.
// align_i=0 anchors matched bytes at the MSB end, align_i=1 at the LSB end.
module byte_merge import dict_pkg::*; #(
  parameter int DICT_WORD = DICT_WORD_DEF
) (
  input  match_t               type_i,
  input  logic                 align_i,
  input  logic [DICT_WORD-1:0] dict_i,
  input  logic [DICT_WORD-1:0] lit_i,
  output logic [DICT_WORD-1:0] word_o
);
  localparam int NB = DICT_WORD / 8;

  int            nmatch;
  logic [NB-1:0] from_dict;

  assign nmatch = match_bytes(type_i, NB);

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign from_dict[b]     = align_i ? (b < nmatch) : (b >= NB - nmatch);
    assign word_o[b*8 +: 8] = from_dict[b] ? dict_i[b*8 +: 8] : lit_i[b*8 +: 8];
  end
endmodule

// File: rtl/dict_decompressor.sv
// Dictionary decompressor: merges dictionary bytes with literals, replays unmatched words into
// a circular dictionary, and supports a one-entry-per-cycle flush of the whole dictionary.
module dict_decompressor import dict_pkg::*; #(
  parameter  int DICT_ENTRY = DICT_ENTRY_DEF,
  parameter  int DICT_WORD  = DICT_WORD_DEF,
  localparam int LOC_W      = $clog2(DICT_ENTRY)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_type_matched,
  input  logic                 i_align,
  input  logic [LOC_W-1:0]     i_location,
  input  logic [DICT_WORD-1:0] i_literal,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [DICT_WORD-1:0] o_word
);
  localparam logic [LOC_W-1:0] LAST = LOC_W'(DICT_ENTRY - 1);

  dec_state_t           state_q;
  logic [DICT_WORD-1:0] dict_q [DICT_ENTRY];
  logic [LOC_W-1:0]     wr_ptr_q, wr_ptr_d, fcnt_q;
  logic                 vld_q;
  logic [DICT_WORD-1:0] word_q, word_d, rd_word;
  match_t               mtype;
  logic                 accept, dict_wr;

  assign mtype    = match_t'(i_type_matched);
  assign o_ready  = (state_q == ST_RUN) && (!vld_q || i_ready);
  assign accept   = i_valid && o_ready;
  assign dict_wr  = accept && (mtype != MATCH_FULL);
  assign wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
  assign o_valid  = vld_q;
  assign o_word   = word_q;

  // Locations beyond the last entry fall through the mux and read as zero.
  always_comb begin
    rd_word = '0;
    for (int e = 0; e < DICT_ENTRY; e++)
      if (i_location == LOC_W'(e)) rd_word = dict_q[e];
  end

  byte_merge #(.DICT_WORD(DICT_WORD)) u_merge (
    .type_i  (mtype),
    .align_i (i_align),
    .dict_i  (rd_word),
    .lit_i   (i_literal),
    .word_o  (word_d)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_RUN;
      vld_q    <= 1'b0;
      word_q   <= '0;
      wr_ptr_q <= '0;
      fcnt_q   <= '0;
      for (int e = 0; e < DICT_ENTRY; e++) dict_q[e] <= '0;
    end else begin
      // Output register drains independently of the FSM state.
      if (accept) begin
        vld_q  <= 1'b1;
        word_q <= word_d;
      end else if (i_ready) begin
        vld_q  <= 1'b0;
      end

      case (state_q)
        ST_RUN: begin
          if (dict_wr) begin
            dict_q[wr_ptr_q] <= word_d;
            wr_ptr_q         <= wr_ptr_d;
          end
          if (i_flush) begin
            state_q <= ST_FLUSH;
            fcnt_q  <= '0;
          end
        end
        ST_FLUSH: begin
          dict_q[fcnt_q] <= '0;
          if (fcnt_q == LAST) begin
            state_q  <= ST_RUN;
            fcnt_q   <= '0;
            wr_ptr_q <= '0;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_dict_decompressor.sv
// Self-checking bench: directed table, corner sequences and random traffic against a
// word/array-level reference model of the decompressor.
module tb_dict_decompressor;
  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_align, i_flush, i_ready;
  logic [1:0]  i_type_matched;
  logic [3:0]  i_location;
  logic [31:0] i_literal;
  logic        o_ready, o_valid;
  logic [31:0] o_word;

  always #5 clk = ~clk;

  dict_decompressor dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_type_matched(i_type_matched), .i_align(i_align), .i_location(i_location),
    .i_literal(i_literal), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_word(o_word)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] mdict [16];
  int          mwp, mflush;
  logic        mvld;
  logic [31:0] mword;

  typedef struct {
    logic [1:0]  t;
    logic        al;
    logic [3:0]  loc;
    logic [31:0] lit;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mmerge(input logic [1:0] t, input logic al,
                                         input logic [31:0] d, input logic [31:0] lit);
    int n;
    logic [63:0] m;
    n = (t == 2'd3) ? 4 : (t == 2'd2) ? 3 : (t == 2'd1) ? 2 : 0;
    m = (64'd1 << (8 * n)) - 64'd1;
    if (!al) m = m << (8 * (4 - n));
    return (d & m[31:0]) | (lit & ~m[31:0]);
  endfunction

  task automatic model_reset();
    for (int e = 0; e < 16; e++) mdict[e] = '0;
    mwp = 0; mflush = 0; mvld = 1'b0; mword = '0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_type_matched = 2'd0; i_align = 1'b0; i_location = '0; i_literal = '0;
    model_reset();
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  // One clock: check o_ready before the edge, advance the model, check outputs after it.
  task automatic tick();
    logic exp_rdy, acc;
    logic [31:0] mg;
    exp_rdy = (mflush == 0) && (!mvld || i_ready);
    #1;
    chk("o_ready", {31'd0, o_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    acc = i_valid && exp_rdy;
    if (acc) begin
      mg = mmerge(i_type_matched, i_align, mdict[i_location], i_literal);
      if (i_type_matched != 2'd3) begin
        mdict[mwp] = mg;
        mwp = (mwp + 1) % 16;
      end
      mword = mg; mvld = 1'b1;
    end else if (i_ready) begin
      mvld = 1'b0;
    end
    if (mflush > 0) begin
      mflush--;
      if (mflush == 0) begin
        for (int e = 0; e < 16; e++) mdict[e] = '0;
        mwp = 0;
      end
    end else if (i_flush) begin
      mflush = 16;
    end
    #1;
    chk("o_valid", {31'd0, o_valid}, {31'd0, mvld});
    chk("o_word", o_word, mword);
  endtask

  task automatic send(input logic [1:0] t, input logic al, input logic [3:0] loc,
                      input logic [31:0] lit);
    i_valid = 1'b1; i_type_matched = t; i_align = al; i_location = loc; i_literal = lit;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int lowcnt;
    tbl[0] = '{2'd0, 1'b0, 4'd0, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1] = '{2'd3, 1'b0, 4'd0, 32'h00000000, 32'hDEADBEEF};
    tbl[2] = '{2'd2, 1'b0, 4'd0, 32'h00000011, 32'hDEADBE11};
    tbl[3] = '{2'd1, 1'b1, 4'd0, 32'h12340000, 32'h1234BEEF};
    tbl[4] = '{2'd2, 1'b1, 4'd0, 32'hAA000000, 32'hAAADBEEF};
    tbl[5] = '{2'd3, 1'b0, 4'd1, 32'hFFFFFFFF, 32'hDEADBE11};
    tbl[6] = '{2'd3, 1'b1, 4'd3, 32'h00000000, 32'hAAADBEEF};
    tbl[7] = '{2'd1, 1'b0, 4'd2, 32'h0000CAFE, 32'h1234CAFE};

    do_reset();
    #1;
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_word", o_word, 32'd0);
    chk("rst_o_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed merge table; entry1 read at step 5 confirms wr_ptr was 1 after step 0.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].t, tbl[i].al, tbl[i].loc, tbl[i].lit);
      chk($sformatf("tbl%0d", i), o_word, tbl[i].exp);
    end

    // Pointer wrap: 17 literals, entry0 overwritten by 16
    do_reset();
    for (int i = 0; i <= 16; i++) send(2'd0, 1'b0, 4'd0, 32'(i));
    send(2'd3, 1'b0, 4'd0, 32'h0);
    chk("wrap_loc0", o_word, 32'd16);
    send(2'd3, 1'b0, 4'd1, 32'h0);
    chk("wrap_loc1", o_word, 32'd1);

    // Backpressure hold
    do_reset();
    i_ready = 1'b0;
    send(2'd0, 1'b0, 4'd0, 32'h0BADF00D);
    i_valid = 1'b1; i_type_matched = 2'd0; i_literal = 32'h11111111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_rdy", {31'd0, o_ready}, 32'd0);
      chk("hold_word", o_word, 32'h0BADF00D);
    end
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("hold_release", o_word, 32'h11111111);
    send(2'd3, 1'b0, 4'd2, 32'h0);
    chk("hold_nowrite", o_word, 32'h0);
    send(2'd3, 1'b0, 4'd1, 32'h0);
    chk("hold_entry1", o_word, 32'h11111111);

    // Flush: ready low exactly 16 cycles, dictionary cleared
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    lowcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!o_ready) lowcnt++;
      tick();
    end
    chk("flush_len", 32'(lowcnt), 32'd16);
    send(2'd3, 1'b0, 4'd0, 32'h0);
    chk("flush_loc0", o_word, 32'h0);
    send(2'd3, 1'b0, 4'd1, 32'h0);
    chk("flush_loc1", o_word, 32'h0);

    // Flush coincident with acceptance, then reset mid-flush with o_valid held
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0; i_flush = 1'b1;
    send(2'd0, 1'b0, 4'd0, 32'h00000055);
    i_flush = 1'b0;
    chk("coinc_word", o_word, 32'h00000055);
    for (int k = 0; k < 3; k++) tick();
    #2;
    i_reset = 1'b1;
    #1;
    chk("midrst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_o_word", o_word, 32'd0);
    chk("midrst_o_ready", {31'd0, o_ready}, 32'd1);
    do_reset();
    send(2'd3, 1'b0, 4'd0, 32'h0);
    chk("midrst_loc0", o_word, 32'h0);

    // Coincident flush with full drain: entry written then cleared by flush
    i_flush = 1'b1;
    send(2'd0, 1'b0, 4'd0, 32'hCAFEBABE);
    i_flush = 1'b0;
    chk("coinc2_word", o_word, 32'hCAFEBABE);
    for (int k = 0; k < 16; k++) tick();
    send(2'd3, 1'b0, 4'd0, 32'h0);
    chk("coinc2_cleared", o_word, 32'h0);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      i_valid        = ($urandom_range(0, 3) != 0);
      i_type_matched = 2'($urandom_range(0, 3));
      i_align        = 1'($urandom_range(0, 1));
      i_location     = 4'($urandom_range(0, 15));
      i_literal      = $urandom;
      i_flush        = ($urandom_range(0, 63) == 0);
      i_ready        = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
